// File: rtl/commit_log_buffer_if.sv
// Commit-port bundle between the register-write commit ports and the cosim compare log.
// Member names mirror the log buffer's port list. The master side drives the writes and
// accepts entries. The slave side is the log buffer.
interface commit_log_buffer_if #(
    parameter int unsigned KEY_WIDTH   = 64,
    parameter int unsigned VALUE_WIDTH = 128
);
    logic [KEY_WIDTH-1:0]   wa1_i;
    logic [VALUE_WIDTH-1:0] wd1_i;
    logic                   we1_i;
    logic [KEY_WIDTH-1:0]   wa2_i;
    logic [VALUE_WIDTH-1:0] wd2_i;
    logic                   we2_i;
    logic                   step_done_i;
    logic                   rd_valid_o;
    logic                   rd_ready_i;
    logic [KEY_WIDTH-1:0]   rd_key_o;
    logic [VALUE_WIDTH-1:0] rd_value_o;
    logic                   rd_last_o;

    modport master (
        output wa1_i, wd1_i, we1_i, wa2_i, wd2_i, we2_i, step_done_i, rd_ready_i,
        input  rd_valid_o, rd_key_o, rd_value_o, rd_last_o
    );

    modport slave (
        input  wa1_i, wd1_i, we1_i, wa2_i, wd2_i, we2_i, step_done_i, rd_ready_i,
        output rd_valid_o, rd_key_o, rd_value_o, rd_last_o
    );
endinterface

// File: rtl/commit_log_buffer.sv
// Per-step commit log. Dual-port register writes are merged into a key-deduplicated log
// (last write per key wins) while collecting. The log is then drained in insertion order
// over a valid/ready port when the step closes.
module commit_log_buffer #(
    parameter int unsigned KEY_WIDTH       = 64,
    parameter int unsigned VALUE_WIDTH     = 128,
    parameter int unsigned MAX_ENTRY_COUNT = 16,
    localparam int unsigned CntW = $clog2(MAX_ENTRY_COUNT + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    commit_log_buffer_if.slave   bus,
    output logic [CntW-1:0]      count_o,
    output logic                 overflow_o,
    output logic                 err_o
);
    localparam int unsigned IdxW = (MAX_ENTRY_COUNT > 1) ? $clog2(MAX_ENTRY_COUNT) : 1;
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_ENTRY_COUNT);

    typedef enum logic [0:0] {StCollect, StDrain} state_e;

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [KEY_WIDTH-1:0]   r_key [MAX_ENTRY_COUNT];
    logic [VALUE_WIDTH-1:0] r_val [MAX_ENTRY_COUNT];
    logic [CntW-1:0]        r_count;
    logic [IdxW-1:0]        r_idx;
    logic                   r_overflow;
    logic                   r_err;

    logic            w_hit1, w_hit2;
    logic [IdxW-1:0] w_hit1_idx, w_hit2_idx;
    logic            w_collect, w_drain, w_same;
    logic            w_p1_en, w_p1_upd, w_p1_app, w_p1_drop;
    logic            w_p2_en, w_p2_upd, w_p2_app, w_p2_drop;
    logic [CntW-1:0] w_cnt_mid, w_count_cap;
    logic [IdxW-1:0] w_p1_slot, w_p2_slot;
    logic            w_is_last, w_fire, w_final;

    // Key match of each write port against the valid entries (valid == index below count).
    always_comb begin
        w_hit1     = 1'b0;
        w_hit1_idx = '0;
        w_hit2     = 1'b0;
        w_hit2_idx = '0;
        for (int i = 0; i < MAX_ENTRY_COUNT; i++) begin
            if (CntW'(i) < r_count) begin
                if (r_key[i] == bus.wa1_i) begin
                    w_hit1     = 1'b1;
                    w_hit1_idx = IdxW'(i);
                end
                if (r_key[i] == bus.wa2_i) begin
                    w_hit2     = 1'b1;
                    w_hit2_idx = IdxW'(i);
                end
            end
        end
    end

    // Capture decisions; port 1 is resolved first so port 2 appends behind it.
    always_comb begin
        w_collect   = (r_state == StCollect);
        w_drain     = (r_state == StDrain);
        // Same key on both ports collapses to a single port-2 write.
        w_same      = bus.we1_i && bus.we2_i && (bus.wa1_i == bus.wa2_i);
        w_p1_en     = w_collect && bus.we1_i && !w_same;
        w_p1_upd    = w_p1_en && w_hit1;
        w_p1_app    = w_p1_en && !w_hit1 && (r_count < MaxCnt);
        w_p1_drop   = w_p1_en && !w_hit1 && !(r_count < MaxCnt);
        w_cnt_mid   = r_count + CntW'(w_p1_app);
        w_p2_en     = w_collect && bus.we2_i;
        w_p2_upd    = w_p2_en && w_hit2;
        w_p2_app    = w_p2_en && !w_hit2 && (w_cnt_mid < MaxCnt);
        w_p2_drop   = w_p2_en && !w_hit2 && !(w_cnt_mid < MaxCnt);
        w_count_cap = w_cnt_mid + CntW'(w_p2_app);
        w_p1_slot   = w_hit1 ? w_hit1_idx : r_count[IdxW-1:0];
        w_p2_slot   = w_hit2 ? w_hit2_idx : w_cnt_mid[IdxW-1:0];
        w_is_last   = (CntW'(r_idx) == (r_count - CntW'(1)));
        w_fire      = w_drain && bus.rd_ready_i;
        w_final     = w_fire && w_is_last;
    end

    // Entry storage; validity is tracked by count, so the array itself needs no reset.
    always_ff @(posedge clk_i) begin
        if (w_p1_upd || w_p1_app) begin
            r_key[w_p1_slot] <= bus.wa1_i;
            r_val[w_p1_slot] <= bus.wd1_i;
        end
        if (w_p2_upd || w_p2_app) begin
            r_key[w_p2_slot] <= bus.wa2_i;
            r_val[w_p2_slot] <= bus.wd2_i;
        end
    end

    // Count, drain index and sticky flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count    <= '0;
            r_idx      <= '0;
            r_overflow <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_final) begin
                r_count <= '0;
                r_idx   <= '0;
            end else begin
                if (w_collect) r_count <= w_count_cap;
                if (w_fire)    r_idx   <= r_idx + IdxW'(1);
            end
            if (w_final) begin
                r_overflow <= 1'b0;
            end else if (w_p1_drop || w_p2_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_drain && (bus.we1_i || bus.we2_i || bus.step_done_i)) r_err <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= StCollect;
        else         r_state <= w_state_nxt;
    end

    // FSM next state: an empty step never enters drain.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StCollect: if (bus.step_done_i && (w_count_cap != '0)) w_state_nxt = StDrain;
            StDrain:   if (w_final) w_state_nxt = StCollect;
            default:   w_state_nxt = StCollect;
        endcase
    end

    // FSM outputs; data is forced to zero outside drain.
    always_comb begin
        bus.rd_valid_o = w_drain;
        bus.rd_last_o  = w_drain && w_is_last;
        bus.rd_key_o   = w_drain ? r_key[r_idx] : '0;
        bus.rd_value_o = w_drain ? r_val[r_idx] : '0;
        count_o        = r_count;
        overflow_o     = r_overflow;
        err_o          = r_err;
    end
endmodule

// File: tb/tb_commit_log_buffer.sv
// Bench for commit_log_buffer: directed steps with expected entries queued at step close,
// and a monitor that checks every accepted entry against the queue.
module tb_commit_log_buffer;
    localparam int unsigned KW = 64;
    localparam int unsigned VW = 128;

    typedef struct packed {
        logic [KW-1:0] k;
        logic [VW-1:0] v;
        logic          l;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [4:0] count;
    logic       overflow;
    logic       err;
    exp_t       sb [$];
    int         n_chk  = 0;
    int         n_fail = 0;

    commit_log_buffer_if #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW)) bus ();

    commit_log_buffer #(
        .KEY_WIDTH(KW),
        .VALUE_WIDTH(VW),
        .MAX_ENTRY_COUNT(16)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .bus(bus.slave),
        .count_o(count),
        .overflow_o(overflow),
        .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every accepted entry must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus.rd_valid_o && bus.rd_ready_i) begin
            if (sb.size() == 0) begin
                check("unexpected_entry", 128'(bus.rd_valid_o), 128'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("entry_key", 128'(bus.rd_key_o), 128'(e.k));
                check("entry_value", bus.rd_value_o, e.v);
                check("entry_last", 128'(bus.rd_last_o), 128'(e.l));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e1, input logic [KW-1:0] a1, input logic [VW-1:0] d1,
                         input logic e2, input logic [KW-1:0] a2, input logic [VW-1:0] d2,
                         input logic sd);
        bus.we1_i = e1; bus.wa1_i = a1; bus.wd1_i = d1;
        bus.we2_i = e2; bus.wa2_i = a2; bus.wd2_i = d2;
        bus.step_done_i = sd;
        tick();
        bus.we1_i = 1'b0; bus.we2_i = 1'b0; bus.step_done_i = 1'b0;
    endtask

    task automatic push(input logic [KW-1:0] k, input logic [VW-1:0] v, input logic l);
        exp_t e;
        e.k = k; e.v = v; e.l = l;
        sb.push_back(e);
    endtask

    task automatic drain_wait(input string nm);
        int n = 0;
        while (bus.rd_valid_o && n < 100) begin
            tick();
            n++;
        end
        check({nm, "_drain_done"}, 128'(bus.rd_valid_o), 128'(0));
        check({nm, "_count_zero"}, 128'(count), 128'(0));
        check({nm, "_sb_empty"}, 128'(sb.size()), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.we1_i = 0; bus.wa1_i = '0; bus.wd1_i = '0;
        bus.we2_i = 0; bus.wa2_i = '0; bus.wd2_i = '0;
        bus.step_done_i = 0; bus.rd_ready_i = 1'b1;
        #2;
        check("rst_valid", 128'(bus.rd_valid_o), 128'(0));
        check("rst_count", 128'(count), 128'(0));
        check("rst_flags", 128'({overflow, err, bus.rd_last_o}), 128'(0));
        check("rst_key", 128'(bus.rd_key_o), 128'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // 1: one write per cycle on alternate ports.
        drive(1, 64'h5, 128'hAA, 0, '0, '0, 0);
        check("t1_count1", 128'(count), 128'(1));
        drive(0, '0, '0, 1, 64'h9, 128'hBB, 0);
        check("t1_count2", 128'(count), 128'(2));
        push(64'h5, 128'hAA, 0);
        push(64'h9, 128'hBB, 1);
        drive(0, '0, '0, 0, '0, '0, 1);
        check("t1_valid_rise", 128'(bus.rd_valid_o), 128'(1));
        drain_wait("t1");

        // 2: same key on both ports in one cycle; port 2 wins.
        drive(1, 64'h3, 128'h11, 1, 64'h3, 128'h22, 0);
        check("t2_count", 128'(count), 128'(1));
        push(64'h3, 128'h22, 1);
        drive(0, '0, '0, 0, '0, '0, 1);
        drain_wait("t2");

        // 3: fill the log, then a new key drops while an existing key updates.
        for (int i = 0; i < 16; i++) drive(1, 64'(i), 128'(32'h1000 + i), 0, '0, '0, 0);
        check("t3_full", 128'(count), 128'(16));
        check("t3_no_ovf", 128'(overflow), 128'(0));
        drive(1, 64'h100, 128'h77, 1, 64'h0, 128'hFF, 0);
        check("t3_count_cap", 128'(count), 128'(16));
        check("t3_ovf", 128'(overflow), 128'(1));
        push(64'h0, 128'hFF, 0);
        for (int i = 1; i < 16; i++) push(64'(i), 128'(32'h1000 + i), (i == 15));
        drive(0, '0, '0, 0, '0, '0, 1);
        drain_wait("t3");
        check("t3_ovf_clr", 128'(overflow), 128'(0));

        // 3b: one slot left with two misses; port 1 stored, port 2 dropped.
        for (int i = 0; i < 15; i++) drive(1, 64'(32'h200 + i), 128'(i), 0, '0, '0, 0);
        drive(1, 64'h300, 128'h3A, 1, 64'h301, 128'h3B, 0);
        check("t3b_count", 128'(count), 128'(16));
        check("t3b_ovf", 128'(overflow), 128'(1));
        for (int i = 0; i < 15; i++) push(64'(32'h200 + i), 128'(i), 0);
        push(64'h300, 128'h3A, 1);
        drive(0, '0, '0, 0, '0, '0, 1);
        drain_wait("t3b");

        // 4: stall in drain, then a write during drain flags err and is not logged.
        drive(1, 64'h20, 128'h1, 1, 64'h21, 128'h2, 0);
        bus.rd_ready_i = 1'b0;
        push(64'h20, 128'h1, 0);
        push(64'h21, 128'h2, 1);
        drive(0, '0, '0, 0, '0, '0, 1);
        for (int i = 0; i < 5; i++) begin
            check("t4_stall_valid", 128'(bus.rd_valid_o), 128'(1));
            check("t4_stall_key", 128'(bus.rd_key_o), 128'(64'h20));
            check("t4_stall_value", bus.rd_value_o, 128'h1);
            tick();
        end
        check("t4_no_err", 128'(err), 128'(0));
        drive(1, 64'h55, 128'h99, 0, '0, '0, 0);
        check("t4_err", 128'(err), 128'(1));
        check("t4_count", 128'(count), 128'(2));
        bus.rd_ready_i = 1'b1;
        drain_wait("t4");

        // 5: closing an empty step produces nothing.
        drive(0, '0, '0, 0, '0, '0, 1);
        for (int i = 0; i < 3; i++) begin
            check("t5_no_valid", 128'(bus.rd_valid_o), 128'(0));
            tick();
        end
        drive(1, 64'h7, 128'h70, 0, '0, '0, 0);
        check("t5_still_collect", 128'(count), 128'(1));
        push(64'h7, 128'h70, 1);
        drive(0, '0, '0, 0, '0, '0, 1);
        drain_wait("t5");

        // 6: reset while entry 1 of 3 is presented.
        drive(1, 64'h30, 128'h3, 1, 64'h31, 128'h4, 0);
        drive(1, 64'h32, 128'h5, 0, '0, '0, 0);
        push(64'h30, 128'h3, 0);
        push(64'h31, 128'h4, 0);
        push(64'h32, 128'h5, 1);
        drive(0, '0, '0, 0, '0, '0, 1);
        tick();
        check("t6_entry1_key", 128'(bus.rd_key_o), 128'(64'h31));
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 128'(bus.rd_valid_o), 128'(0));
        check("t6_rst_kv", 128'({bus.rd_key_o, bus.rd_last_o}), 128'(0));
        check("t6_rst_value", bus.rd_value_o, 128'h0);
        check("t6_rst_count", 128'(count), 128'(0));
        check("t6_rst_flags", 128'({overflow, err}), 128'(0));
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
        drive(0, '0, '0, 1, 64'h40, 128'h4, 0);
        push(64'h40, 128'h4, 1);
        drive(0, '0, '0, 0, '0, '0, 1);
        drain_wait("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
